multiword_seq_adder: RTL and testbench
======================================

// Module: multiword_seq_adder
// PURPOSE
//  Multi-cycle wide adder. It accepts two W-bit operands (W = N*K) over a valid/ready
//  handshake and adds them one N-bit slice per clock, least significant slice first.
//  Each slice goes through one internal carry_lookahead_adder #(N) instance, and the
//  slice carry is chained through a carry register. It sits between operand producers
//  (register file / ALU issue) and result consumers, and produces sum, carry-out and
//  signed overflow.
// PARAMETERS
//  N  4  slice width; the width of the internal carry_lookahead_adder instance
//  K  4  number of slices per operation (K >= 1); W = N*K is a localparam
// PORTS
//  clk        in   1  single clock; all state updates on the rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  in_valid   in   1  operands a/b/cin are valid
//  in_ready   out  1  block can accept an operation (high only in IDLE)
//  a          in   W  operand A
//  b          in   W  operand B
//  cin        in   1  carry-in to slice 0
//  out_valid  out  1  sum/cout/ovf are valid (high only in DONE)
//  out_ready  in   1  consumer accepts the result
//  sum        out  W  A + B + cin, modulo 2^W
//  cout       out  1  carry out of slice K-1
//  ovf        out  1  signed overflow: (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1])
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, slice idx=0, carry reg=0, sum=0, cout=0, ovf=0,
//    out_valid=0, in_ready=1. Inputs are ignored while rst_n=0. Reset aborts any
//    operation in flight with no partial result emitted.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch a, b; carry reg<=cin;
//    sum<=0; idx<=0; go to RUN.
//  - RUN: in_ready=0, out_valid=0. Each edge: the adder gets a[idx*N+:N], b[idx*N+:N]
//    and the carry reg. Then sum[idx*N+:N]<=Sum, carry reg<=Cout, idx<=idx+1. On the
//    edge that processes idx==K-1: cout<=Cout, ovf<=overflow from the final MSB,
//    idx<=0, go to DONE.
//  - DONE: out_valid=1; sum/cout/ovf stay stable until out_valid&&out_ready at an edge.
//    Then out_valid<=0 and the block goes to IDLE.
//  - Latency: acceptance at edge E0 gives out_valid=1 after edge E0+K (K RUN cycles).
//    Minimum issue interval is K+2 cycles (one DONE cycle, one IDLE cycle).
//  - Back-pressure: out_ready may be held low indefinitely. The block stays in DONE,
//    in_ready=0, and outputs do not change. in_valid is ignored outside IDLE.
//  - The sum bits are only meaningful while out_valid=1. Intermediate slices are
//    visible during RUN but must not be consumed.
//  - Widths: idx is $clog2(K) bits (minimum 1). With K=1, RUN lasts one cycle.
//    Arithmetic wraps modulo 2^W; the carry is reported only through cout.
//  - Operand registers are internal copies, so a/b may change after acceptance
//    without affecting the result.
// TESTING
//  1. N=4,K=4: a=16'h00FF, b=16'h0001, cin=0, accepted at E0 -> out_valid after E0+4,
//     sum=16'h0100, cout=0, ovf=0.
//  2. a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0 (full ripple across
//     all 4 slices through the carry reg).
//  3. a=16'h7FFF, b=16'h0000, cin=1 -> sum=16'h8000, cout=0, ovf=1; then
//     a=16'h8000, b=16'h8000, cin=0 -> sum=0, cout=1, ovf=1.
//  4. Back-pressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new
//     operands -> sum/cout/ovf stable, in_ready=0, no new op accepted. out_ready=1 ->
//     IDLE on the next edge, and the pending op is accepted on the edge after that.
//  5. Reset mid-RUN: drop rst_n after 2 RUN cycles -> immediately state IDLE, all
//     outputs 0, in_ready=1. After release, a fresh op 16'h1234+16'h1111 -> 16'h2345.
//  6. K=1,N=8: a=8'hF0, b=8'h20, cin=1 -> out_valid after one RUN cycle, sum=8'h11,
//     cout=1, ovf=0. Random compare vs a+b+cin for 1000 ops with random out_ready.

Source files
------------

// File: rtl/multiword_seq_adder.sv
// Multi-cycle W-bit adder (W = N*K): one N-bit carry-lookahead slice per clock,
// LS slice first, carry chained through a register, valid/ready on both sides.

module carry_lookahead_adder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         acc;
    logic         pp;

    // Each carry is a flat sum of generate terms masked by the propagate chain.
    always_comb begin
        g   = a & b;
        p   = a ^ b;
        c   = '0;
        acc = 1'b0;
        pp  = 1'b0;
        c[0] = cin;
        for (int i = 0; i < int'(N); i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
        sum  = p ^ c[N-1:0];
        cout = c[N];
    end
endmodule

module multiword_seq_adder #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*K-1:0]     a,
    input  logic [N*K-1:0]     b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*K-1:0]     sum,
    output logic               cout,
    output logic               ovf
);
    localparam int unsigned W  = N * K;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic          carry, carry_nx;
    logic [W-1:0]  a_q, a_nx;
    logic [W-1:0]  b_q, b_nx;
    logic [W-1:0]  sum_nx;
    logic          cout_nx;
    logic          ovf_nx;

    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;

    assign slice_a = N'(a_q >> (idx * N));
    assign slice_b = N'(b_q >> (idx * N));

    carry_lookahead_adder #(.N(N)) u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            carry     <= carry_nx;
            a_q       <= a_nx;
            b_q       <= b_nx;
            sum       <= sum_nx;
            cout      <= cout_nx;
            ovf       <= ovf_nx;
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        carry_nx = carry;
        a_nx     = a_q;
        b_nx     = b_q;
        sum_nx   = sum;
        cout_nx  = cout;
        ovf_nx   = ovf;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nx     = a;
                    b_nx     = b;
                    carry_nx = cin;
                    sum_nx   = '0;
                    idx_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // sum was cleared on accept, so OR-ing the shifted slice is a slice write
                sum_nx   = sum | (W'(slice_sum) << (idx * N));
                carry_nx = slice_cout;
                if (idx == IW'(K - 1)) begin
                    cout_nx  = slice_cout;
                    ovf_nx   = (a_q[W-1] == b_q[W-1]) && (slice_sum[N-1] != a_q[W-1]);
                    idx_nx   = '0;
                    state_nx = DONE;
                end else begin
                    idx_nx = IW'(idx + 1'b1);
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multiword_seq_adder.sv
// Directed and random checks for multiword_seq_adder at N=4,K=4 and N=8,K=1.

module tb_multiword_seq_adder;
    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
    logic [15:0] a, b, sum;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    multiword_seq_adder #(.N(4), .K(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    multiword_seq_adder #(.N(8), .K(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic wait_ready16();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // Issue one op on the 16-bit DUT, return result and cycles from accept to out_valid.
    task automatic do_op16(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                           output logic [15:0] s, output logic c, output logic o,
                           output int lat);
        wait_ready16();
        a = oa; b = ob; cin = oc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~oa; b = ~ob;
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) lat = 99;
        s = sum; c = cout; o = ovf;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[8];
        logic [15:0] s;
        logic        c, o;
        int          lat;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op16(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, o, lat);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
        end

        // Back-pressure: result held in DONE while a new op waits at the input.
        wait_ready16();
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0001; b = 16'h0001;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'h2345);
            check("bp_cout_ovf", 32'({cout, ovf}), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("bp_pending_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_pending_latency", 32'(lat), 32'd4);
        check("bp_pending_sum", 32'(sum), 32'h0002);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset two cycles into RUN: partial sum discarded, back to IDLE at once.
        wait_ready16();
        a = 16'hFFFF; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op16(16'h1234, 16'h1111, 1'b0, s, c, o, lat);
        check("post_rst_sum", 32'(s), 32'h2345);
        check("post_rst_latency", 32'(lat), 32'd4);

        // K=1 instance: directed vector, then random ops with random stalls.
        for (int i = 0; i < 1001; i++) begin
            logic [7:0] ea, eb;
            logic       ec;
            logic [8:0] full;
            logic       eo;
            int         n;
            if (i == 0) begin
                ea = 8'hF0; eb = 8'h20; ec = 1'b1;
            end else begin
                ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
            end
            full = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
            eo   = (ea[7] == eb[7]) && (full[7] != ea[7]);
            n = 0;
            @(negedge clk);
            while (!in_ready8 && n < 30) begin
                @(negedge clk);
                n++;
            end
            a8 = ea; b8 = eb; cin8 = ec; in_valid8 = 1'b1;
            @(posedge clk);
            #1;
            in_valid8 = 1'b0;
            a8 = ~ea;
            n = 0;
            while (n < 30) begin
                @(posedge clk);
                #1;
                n++;
                if (out_valid8) break;
            end
            if (!out_valid8) n = 99;
            if (i == 0) begin
                check("k1_latency", 32'(n), 32'd1);
                check("k1_sum", 32'(sum8), 32'h11);
                check("k1_cout", 32'(cout8), 32'd1);
                check("k1_ovf", 32'(ovf8), 32'd0);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check($sformatf("k1_rand%0d", i), {20'd0, 1'(n != 1), out_valid8, cout8, ovf8, sum8},
                  {20'd0, 1'b0, 1'b1, full[8], eo, full[7:0]});
            out_ready8 = 1'b1;
            @(posedge clk);
            #1;
            out_ready8 = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
